// File: rtl/ahb_pkg.sv
// Shared AHB encodings, burst-length helper and arbiter state type.
// ARB_LOCKED only exists when AHB_ARB_LOCK_EN is defined.
package ahb_pkg;

    localparam int BEAT_CNT_W = 5;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        ARB_PARK   = 2'd0,
        ARB_OWN    = 2'd1,
        ARB_BURST  = 2'd2
`ifdef AHB_ARB_LOCK_EN
        , ARB_LOCKED = 2'd3
`endif
    } arb_state_e;

    // Fixed-length beat count; 0 means undefined length (SINGLE/INCR).
    function automatic logic [BEAT_CNT_W-1:0] burst_beats(input logic [2:0] burst);
        case (burst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arb_beat_cnt.sv
// Remaining-beat counter for fixed-length bursts: load, decrement, hold,
// and a flag marking the last outstanding beat.
module ahb_arb_beat_cnt
    import ahb_pkg::*;
(
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  load,
    input  logic [BEAT_CNT_W-1:0] load_beats,
    input  logic                  dec,
    output logic [BEAT_CNT_W-1:0] count,
    output logic                  last
);

    logic [BEAT_CNT_W-1:0] cnt_q;

    // A load also accounts for the NONSEQ beat that triggered it.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_beats - 5'd1;
        end else if (dec && cnt_q != '0) begin
            cnt_q <= cnt_q - 5'd1;
        end
    end

    assign count = cnt_q;
    assign last  = (cnt_q == 5'd1);

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB bus arbiter with fixed-burst protection and bus parking.
// Define AHB_ARB_LOCK_EN to honour hlock (ARB_LOCKED state, hmastlock).
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter  int NUM_MASTERS    = 4,
    parameter  int DEFAULT_MASTER = 0,
    localparam int MW             = $clog2(NUM_MASTERS)
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic [2:0]             hburst,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MW-1:0]          hmaster,
    output logic                   hmastlock,
    output logic [1:0]             dbg_state
);

    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

    arb_state_e            state_q, state_n;
    logic [MW-1:0]         gidx_q, gidx_n;
    logic [MW-1:0]         ptr_q, ptr_n;
    logic [MW-1:0]         hmaster_q;
    logic [NUM_MASTERS-1:0] hgrant_q;
    logic                  settled;
    logic                  do_arb;
    logic [MW:0]           pick;
    logic [BEAT_CNT_W-1:0] beats;
    logic [BEAT_CNT_W-1:0] cnt_val;
    logic                  cnt_last;
    logic                  cnt_load;
    logic                  cnt_dec;

    // First requester after 'last', wrapping; MSB flags that one was found.
    function automatic logic [MW:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [MW-1:0] last);
        logic [MW:0]   r;
        logic [MW-1:0] idx;
        r = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = MW'((int'(last) + i) % NUM_MASTERS);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
        logic [NUM_MASTERS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // hready is the only flow control: a cycle with hready=1 completes the
    // current address phase; hready=0 stalls every register in this block.
    // Bus signals belong to the granted master only once hmaster caught up.
    assign settled = (hmaster_q == gidx_q);
    assign pick    = rr_pick(hbusreq, ptr_q);
    assign beats   = burst_beats(hburst);

    always_comb begin
        state_n  = state_q;
        gidx_n   = gidx_q;
        ptr_n    = ptr_q;
        do_arb   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (hready) begin
            case (state_q)
                ARB_PARK: do_arb = 1'b1;
                ARB_OWN: begin
                    if (settled) begin
                        if (htrans == HTRANS_NONSEQ && beats != '0) begin
                            cnt_load = 1'b1;
                            state_n  = ARB_BURST;
                        end else if (htrans == HTRANS_IDLE || !hbusreq[gidx_q]) begin
                            do_arb = 1'b1;
                        end
                    end
                end
                ARB_BURST: begin
                    if (settled) begin
                        if (htrans == HTRANS_SEQ && cnt_val != '0) begin
                            cnt_dec = 1'b1;
                            do_arb  = cnt_last;
                        end else if (htrans == HTRANS_IDLE) begin
                            do_arb = 1'b1;
                        end
                    end
                end
`ifdef AHB_ARB_LOCK_EN
                ARB_LOCKED: begin
                    if (settled) begin
                        if (htrans == HTRANS_NONSEQ && beats != '0) begin
                            cnt_load = 1'b1;
                        end else if (htrans == HTRANS_SEQ && cnt_val != '0) begin
                            cnt_dec = 1'b1;
                        end
                        // Unlocking mid-burst still lets the burst finish.
                        if (!hlock[gidx_q] && htrans != HTRANS_BUSY) begin
                            if (cnt_load || (cnt_dec && !cnt_last)) state_n = ARB_BURST;
                            else                                    do_arb  = 1'b1;
                        end
                    end
                end
`endif
                default: do_arb = 1'b1;
            endcase
        end

        if (do_arb) begin
`ifdef AHB_ARB_LOCK_EN
            if (settled && state_q != ARB_PARK && hlock[gidx_q]) begin
                state_n = ARB_LOCKED;
            end else
`endif
            if (pick[MW]) begin
                gidx_n  = pick[MW-1:0];
                ptr_n   = pick[MW-1:0];
                state_n = ARB_OWN;
`ifdef AHB_ARB_LOCK_EN
                if (hlock[pick[MW-1:0]]) state_n = ARB_LOCKED;
`endif
            end else begin
                gidx_n  = DEF_IDX;
                state_n = ARB_PARK;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= ARB_PARK;
            gidx_q    <= DEF_IDX;
            ptr_q     <= DEF_IDX;
            hmaster_q <= DEF_IDX;
            hgrant_q  <= onehot(DEF_IDX);
        end else if (hready) begin
            state_q   <= state_n;
            gidx_q    <= gidx_n;
            ptr_q     <= ptr_n;
            hmaster_q <= gidx_q;
            hgrant_q  <= onehot(gidx_n);
        end
    end

    ahb_arb_beat_cnt u_beat_cnt (
        .hclk       (hclk),
        .hreset     (hreset),
        .load       (cnt_load),
        .load_beats (beats),
        .dec        (cnt_dec),
        .count      (cnt_val),
        .last       (cnt_last)
    );

`ifdef AHB_ARB_LOCK_EN
    logic mastlock_q;

    always_ff @(posedge hclk) begin
        if (hreset)      mastlock_q <= 1'b0;
        else if (hready) mastlock_q <= hlock[gidx_q];
    end

    assign hmastlock = mastlock_q;
`else
    logic unused_hlock;
    assign unused_hlock = ^hlock;
    assign hmastlock    = 1'b0;
`endif

    assign hgrant    = hgrant_q;
    assign hmaster   = hmaster_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: driver pushes the expected post-edge
// {hgrant, hmaster, hmastlock, state} per cycle, a monitor pops and compares.
module tb_ahb_arbiter;
    import ahb_pkg::*;

    localparam int EW = 9;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;
    logic [1:0] dbg_state;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            total = 0;
    int            bad   = 0;
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] mon_act;
    string         mon_nm;

    ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock),
        .dbg_state (dbg_state)
    );

    always #5 hclk = ~hclk;

    task automatic step(input string nm, input logic rst, input logic [3:0] req,
                        input logic [3:0] lck, input logic [1:0] tr, input logic [2:0] bu,
                        input logic rdy, input logic [3:0] eg, input logic [1:0] em,
                        input logic el, input logic [1:0] es);
        @(negedge hclk);
        hreset  = rst;
        hbusreq = req;
        hlock   = lck;
        htrans  = tr;
        hburst  = bu;
        hready  = rdy;
        exp_q.push_back({eg, em, el, es});
        name_q.push_back(nm);
    endtask

    task automatic st(input string nm, input logic [3:0] req, input logic [1:0] tr,
                      input logic [2:0] bu, input logic [3:0] eg, input logic [1:0] em,
                      input logic [1:0] es);
        step(nm, 1'b0, req, 4'b0000, tr, bu, 1'b1, eg, em, 1'b0, es);
    endtask

    task automatic do_reset();
        step("reset", 1'b1, 4'b0000, 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 1'b1,
             4'b0001, 2'd0, 1'b0, ARB_PARK);
    endtask

    always @(posedge hclk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            mon_act = {hgrant, hmaster, hmastlock, dbg_state};
            total++;
            if (mon_act !== mon_exp) begin
                bad++;
                $display("FAIL %s: got grant=%b master=%0d lock=%b state=%0d, want grant=%b master=%0d lock=%b state=%0d",
                         mon_nm, mon_act[8:5], mon_act[4:3], mon_act[2], mon_act[1:0],
                         mon_exp[8:5], mon_exp[4:3], mon_exp[2], mon_exp[1:0]);
            end
        end
    end

    initial begin
        hreset  = 1'b1;
        hbusreq = '0;
        hlock   = '0;
        htrans  = HTRANS_IDLE;
        hburst  = HBURST_SINGLE;
        hready  = 1'b1;

        // Reset and park
        do_reset();
        do_reset();
        st("park0", 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 4'b0001, 2'd0, ARB_PARK);
        st("park1", 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 4'b0001, 2'd0, ARB_PARK);

        // Master 1 INCR4, then handover to master 2
        st("m1_grant", 4'b0110, HTRANS_IDLE,   HBURST_SINGLE, 4'b0010, 2'd0, ARB_OWN);
        st("m1_hmast", 4'b0110, HTRANS_IDLE,   HBURST_SINGLE, 4'b0010, 2'd1, ARB_OWN);
        st("m1_b1",    4'b0110, HTRANS_NONSEQ, HBURST_INCR4,  4'b0010, 2'd1, ARB_BURST);
        st("m1_b2",    4'b0110, HTRANS_SEQ,    HBURST_INCR4,  4'b0010, 2'd1, ARB_BURST);
        st("m1_b3",    4'b0110, HTRANS_SEQ,    HBURST_INCR4,  4'b0010, 2'd1, ARB_BURST);
        st("m1_b4",    4'b0110, HTRANS_SEQ,    HBURST_INCR4,  4'b0100, 2'd1, ARB_OWN);
        st("m2_hmast", 4'b0100, HTRANS_IDLE,   HBURST_SINGLE, 4'b0100, 2'd2, ARB_OWN);

        // Master 2 INCR8: request dropped after beat 2, wait states on beat 5
        st("m2_b1", 4'b0100, HTRANS_NONSEQ, HBURST_INCR8, 4'b0100, 2'd2, ARB_BURST);
        st("m2_b2", 4'b0100, HTRANS_SEQ,    HBURST_INCR8, 4'b0100, 2'd2, ARB_BURST);
        st("m2_b3", 4'b0001, HTRANS_SEQ,    HBURST_INCR8, 4'b0100, 2'd2, ARB_BURST);
        st("m2_b4", 4'b0001, HTRANS_SEQ,    HBURST_INCR8, 4'b0100, 2'd2, ARB_BURST);
        for (int w = 0; w < 3; w++)
            step("m2_wait", 1'b0, 4'b0001, 4'b0000, HTRANS_SEQ, HBURST_INCR8, 1'b0,
                 4'b0100, 2'd2, 1'b0, ARB_BURST);
        st("m2_b5", 4'b0001, HTRANS_SEQ,  HBURST_INCR8,  4'b0100, 2'd2, ARB_BURST);
        st("m2_b6", 4'b0001, HTRANS_SEQ,  HBURST_INCR8,  4'b0100, 2'd2, ARB_BURST);
        st("m2_b7", 4'b0001, HTRANS_SEQ,  HBURST_INCR8,  4'b0100, 2'd2, ARB_BURST);
        st("m2_b8", 4'b0001, HTRANS_SEQ,  HBURST_INCR8,  4'b0001, 2'd2, ARB_OWN);
        st("m0_hm", 4'b0001, HTRANS_IDLE, HBURST_SINGLE, 4'b0001, 2'd0, ARB_OWN);
        st("repark", 4'b0000, HTRANS_IDLE, HBURST_SINGLE, 4'b0001, 2'd0, ARB_PARK);

        // All four requesting with SINGLE transfers: owners 1,2,3,0,1
        do_reset();
        for (int k = 0; k < 5; k++) begin
            logic [1:0] prv;
            logic [1:0] nxt;
            logic [3:0] g;
            prv = 2'(k % 4);
            nxt = 2'((k + 1) % 4);
            g   = 4'b0001 << nxt;
            st("rr_arb",  4'b1111, HTRANS_IDLE,   HBURST_SINGLE, g, prv, ARB_OWN);
            st("rr_hand", 4'b1111, HTRANS_IDLE,   HBURST_SINGLE, g, nxt, ARB_OWN);
            st("rr_xfer", 4'b1111, HTRANS_NONSEQ, HBURST_SINGLE, g, nxt, ARB_OWN);
        end

        // Master 3 INCR held while others request, then drop; reset mid-burst
        do_reset();
        st("m3_grant", 4'b1000, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd0, ARB_OWN);
        st("m3_hmast", 4'b1111, HTRANS_IDLE,   HBURST_SINGLE, 4'b1000, 2'd3, ARB_OWN);
        st("m3_incr0", 4'b1111, HTRANS_NONSEQ, HBURST_INCR,   4'b1000, 2'd3, ARB_OWN);
        for (int s = 0; s < 3; s++)
            st("m3_incr", 4'b1111, HTRANS_SEQ, HBURST_INCR, 4'b1000, 2'd3, ARB_OWN);
        st("m3_drop",  4'b0111, HTRANS_SEQ,    HBURST_INCR,   4'b0001, 2'd3, ARB_OWN);
        st("m0_hmast", 4'b0111, HTRANS_IDLE,   HBURST_SINGLE, 4'b0001, 2'd0, ARB_OWN);
        st("m2_grant", 4'b0100, HTRANS_IDLE,   HBURST_SINGLE, 4'b0100, 2'd0, ARB_OWN);
        st("m2_hmast", 4'b0100, HTRANS_IDLE,   HBURST_SINGLE, 4'b0100, 2'd2, ARB_OWN);
        st("m2_i16a",  4'b0100, HTRANS_NONSEQ, HBURST_INCR16, 4'b0100, 2'd2, ARB_BURST);
        st("m2_i16b",  4'b0100, HTRANS_SEQ,    HBURST_INCR16, 4'b0100, 2'd2, ARB_BURST);
        step("rst_mid", 1'b1, 4'b0100, 4'b0000, HTRANS_SEQ, HBURST_INCR16, 1'b0,
             4'b0001, 2'd0, 1'b0, ARB_PARK);
        st("post_rst", 4'b1111, HTRANS_IDLE, HBURST_SINGLE, 4'b0010, 2'd0, ARB_OWN);
        st("post_hm",  4'b1111, HTRANS_IDLE, HBURST_SINGLE, 4'b0010, 2'd1, ARB_OWN);

        // Master 1 with hlock over two INCR4 bursts, master 0 requesting
        do_reset();
`ifdef AHB_ARB_LOCK_EN
        step("lk_grant", 1'b0, 4'b0011, 4'b0010, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0, ARB_LOCKED);
        step("lk_hmast", 1'b0, 4'b0011, 4'b0010, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd1, 1'b1, ARB_LOCKED);
        step("lk_a1",    1'b0, 4'b0011, 4'b0010, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b1, ARB_LOCKED);
        for (int s = 0; s < 3; s++)
            step("lk_a", 1'b0, 4'b0011, 4'b0010, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b1, ARB_LOCKED);
        step("lk_b1",    1'b0, 4'b0011, 4'b0010, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b1, ARB_LOCKED);
        for (int s = 0; s < 3; s++)
            step("lk_b", 1'b0, 4'b0011, 4'b0010, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b1, ARB_LOCKED);
        step("lk_rel",   1'b0, 4'b0011, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0001, 2'd1, 1'b0, ARB_OWN);
`else
        step("lk_grant", 1'b0, 4'b0011, 4'b0010, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0, ARB_OWN);
        step("lk_hmast", 1'b0, 4'b0011, 4'b0010, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd1, 1'b0, ARB_OWN);
        step("lk_a1",    1'b0, 4'b0011, 4'b0010, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0, ARB_BURST);
        step("lk_a2",    1'b0, 4'b0011, 4'b0010, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0, ARB_BURST);
        step("lk_a3",    1'b0, 4'b0011, 4'b0010, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0010, 2'd1, 1'b0, ARB_BURST);
        step("lk_a4",    1'b0, 4'b0011, 4'b0010, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0001, 2'd1, 1'b0, ARB_OWN);
        step("lk_b1",    1'b0, 4'b0011, 4'b0010, HTRANS_NONSEQ, HBURST_INCR4,  1'b1, 4'b0001, 2'd0, 1'b0, ARB_OWN);
        for (int s = 0; s < 3; s++)
            step("lk_b", 1'b0, 4'b0011, 4'b0010, HTRANS_SEQ,    HBURST_INCR4,  1'b1, 4'b0001, 2'd0, 1'b0, ARB_OWN);
        step("lk_rel",   1'b0, 4'b0011, 4'b0000, HTRANS_IDLE,   HBURST_SINGLE, 1'b1, 4'b0010, 2'd0, 1'b0, ARB_OWN);
`endif

        // Let the monitor drain the queue, bounded
        repeat (2) @(posedge hclk);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
